handshake_constant_seq: RTL

Parametrised successor to the single-value handshake constant source. Each accepted control token releases the next entry of a compile-time constant table, for example a coefficient or breakpoint list in the softclip datapath. The output is a registered one-slot elastic buffer with full throughput. Table walk is configurable as wrap-around or saturate-at-last, with a synchronous rewind input.

---
 rtl/handshake_constant_seq_if.sv | 37 +++
 rtl/handshake_constant_seq.sv | 80 ++++++++
 2 files changed

// File: rtl/handshake_constant_seq_if.sv
// Handshake bundle for the constant-table sequencer:
// control token in, indexed constant token out.
interface handshake_constant_seq_if #(
    parameter int DATA_WIDTH = 18,
    parameter int IDX_W      = 2
);
    logic                  ctrl_valid;
    logic                  ctrl_ready;
    logic                  restart;
    logic [DATA_WIDTH-1:0] outs;
    logic [IDX_W-1:0]      outs_index;
    logic                  outs_last;
    logic                  outs_valid;
    logic                  outs_ready;

    modport master (
        output ctrl_valid,
        output restart,
        output outs_ready,
        input  ctrl_ready,
        input  outs,
        input  outs_index,
        input  outs_last,
        input  outs_valid
    );

    modport slave (
        input  ctrl_valid,
        input  restart,
        input  outs_ready,
        output ctrl_ready,
        output outs,
        output outs_index,
        output outs_last,
        output outs_valid
    );
endinterface

// File: rtl/handshake_constant_seq.sv
// Releases successive entries of a constant table, one per accepted
// control token, through a registered one-slot elastic output buffer.
module handshake_constant_seq #(
    parameter int                            DATA_WIDTH = 18,
    parameter int                            DEPTH      = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0]   VALUES     = '0,
    parameter bit                            WRAP       = 1'b1,
    localparam int                           IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    handshake_constant_seq_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      eidx;
    logic [IDX_W-1:0]      nidx;
    logic [DATA_WIDTH-1:0] tbl_val;
    logic [DATA_WIDTH-1:0] data_q;
    logic [IDX_W-1:0]      index_q;
    logic                  valid_q;
    logic                  ctrl_fire;
    logic                  out_fire;

    // The only combinational path: outs_ready -> ctrl_ready.
    assign bus.ctrl_ready = !valid_q || bus.outs_ready;
    assign ctrl_fire      = bus.ctrl_valid && bus.ctrl_ready;
    assign out_fire       = valid_q && bus.outs_ready;

    assign eidx = bus.restart ? '0 : idx;

    if (DEPTH == 1) begin : g_one
        assign tbl_val = VALUES[DATA_WIDTH-1:0];
    end else begin : g_tbl
        logic [DATA_WIDTH-1:0] tbl [DEPTH];
        for (genvar k = 0; k < DEPTH; k++) begin : g_ent
            assign tbl[k] = VALUES[k*DATA_WIDTH +: DATA_WIDTH];
        end
        assign tbl_val = tbl[eidx];
    end

    always_comb begin
        nidx = LAST;
        if (eidx < LAST) begin
            nidx = eidx + IDX_W'(1);
        end else if (WRAP) begin
            nidx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            idx     <= '0;
        end else if (ctrl_fire) begin
            // A new token overwrites any one leaving this cycle: no bubble.
            valid_q <= 1'b1;
            data_q  <= tbl_val;
            index_q <= eidx;
            idx     <= nidx;
        end else begin
            if (out_fire) begin
                valid_q <= 1'b0;
            end
            if (bus.restart) begin
                idx <= '0;
            end
        end
    end

    assign bus.outs       = data_q;
    assign bus.outs_index = index_q;
    assign bus.outs_valid = valid_q;
    assign bus.outs_last  = valid_q && (index_q == LAST);

endmodule
